// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write sequencer.
//   - lcd_state_e : sequencer FSM states
//   - lcd_entry_t : one queued LCD write, {rs, data}
//   - LCD_CMD_*   : command codes that need the long execution delay
//   - lcd_is_long_cmd() : classifies an entry as clear/home
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } lcd_state_e;

   localparam int LCD_ENTRY_W = 9;
   typedef logic [LCD_ENTRY_W-1:0] lcd_entry_t;

   localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFE;
   localparam logic [7:0] LCD_CMD_HOME      = 8'h02;

   // Clear display (0x01) and return home (0x02/0x03) are the slow commands.
   function automatic logic lcd_is_long_cmd(input lcd_entry_t e);
      return !e[8] && ((e[7:0] == LCD_CMD_CLEAR) ||
                       ((e[7:0] & LCD_CMD_HOME_MASK) == LCD_CMD_HOME));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding queued LCD writes.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (flushes the FIFO)
//   push, din    : write din; caller only pushes when !full or popping
//   pop, dout    : dout shows the head; caller only pops when !empty
//   full, empty  : occupancy flags decoded from the registered level
//   level        : current occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;

   // Storage is not reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_level == (AW+1)'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Buffers CPU byte writes to the character LCD and replays them on the LCD
// bus with programmable setup / enable-pulse / hold / execution delays.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/wr_rs/wr_data : push request {rs, data}
//   clr_overflow        : clears the sticky overflow flag
//   full, busy, level   : FIFO full, activity, FIFO occupancy
//   overflow            : sticky, set when a push is dropped
//   lcd_data, lcd_ctrl  : LCD data bus and {RS, RW}; RW is always 0
//   lcd_enable          : LCD E strobe
module lcd_write_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH            = 8,
   parameter int SETUP_CYCLES     = 2,
   parameter int PULSE_CYCLES     = 12,
   parameter int HOLD_CYCLES      = 2,
   parameter int EXEC_CYCLES      = 2000,
   parameter int LONG_EXEC_CYCLES = 80000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic                     wr_rs,
   input  logic [7:0]               wr_data,
   input  logic                     clr_overflow,
   output logic                     full,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               lcd_data,
   output logic [1:0]               lcd_ctrl,
   output logic                     lcd_enable
);

   localparam int CW = $clog2(LONG_EXEC_CYCLES + 1);
   // A state lasting N cycles loads N-1 and exits when the counter reads 0.
   localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] C_PULSE = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] C_EXEC  = CW'(EXEC_CYCLES - 1);
   localparam logic [CW-1:0] C_LONG  = CW'(LONG_EXEC_CYCLES - 1);

   lcd_state_e r_state;
   lcd_state_e w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   logic        w_pop;
   logic        w_push;
   logic        w_drop;
   logic        w_full;
   logic        w_empty;
   lcd_entry_t  w_head;

   logic [7:0]  r_lcd_data;
   logic        r_rs;
   logic        r_long;
   logic        r_enable;
   logic        r_busy;
   logic        r_overflow;

   // A pop on the same edge frees a slot, so a push into a full FIFO is
   // still accepted then.
   assign w_push = wr_en && (!w_full || w_pop);
   assign w_drop = wr_en && !w_push;

   sync_fifo #(
      .WIDTH (LCD_ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({wr_rs, wr_data}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = C_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_PULSE;
               w_cnt_nxt   = C_PULSE;
            end
         end
         ST_PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = C_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = r_long ? C_LONG : C_EXEC;
            end
         end
         ST_WAIT: begin
            // Chain straight into the next entry to avoid an IDLE bubble.
            if (r_cnt == '0) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_SETUP;
                  w_cnt_nxt   = C_SETUP;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lcd_data <= '0;
         r_rs       <= 1'b0;
         r_long     <= 1'b0;
         r_enable   <= 1'b0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) begin
            {r_rs, r_lcd_data} <= w_head;
            r_long             <= lcd_is_long_cmd(w_head);
         end
         r_enable <= (w_state_nxt == ST_PULSE);
         // Uses the pre-edge FIFO state, so busy lags the first push by one edge.
         r_busy   <= (w_state_nxt != ST_IDLE) || !w_empty;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_overflow)
            r_overflow <= 1'b0;
      end
   end

   assign full       = w_full;
   assign busy       = r_busy;
   assign overflow   = r_overflow;
   assign lcd_data   = r_lcd_data;
   assign lcd_ctrl   = {r_rs, 1'b0};
   assign lcd_enable = r_enable;

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequences CPU-issued writes to the character LCD so that back-to-back MMIO stores are legal. The block buffers byte writes in a small FIFO and drives the LCD bus (data, RS/RW, E) with programmable setup, enable-pulse, hold and command-execution delays. It sits between the CPU data port (MMIO region `data_addr[31]=1`, RS taken from `data_addr[0]`) and the LCD pins, replacing direct register drive of the pins.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `SETUP_CYCLES`, 2: clk cycles RS/data are stable before E rises; ≥1.
- `PULSE_CYCLES`, 12: clk cycles E is high; ≥1.
- `HOLD_CYCLES`, 2: clk cycles RS/data are held after E falls; ≥1.
- `EXEC_CYCLES`, 2000: wait after hold for normal commands and data; ≥1.
- `LONG_EXEC_CYCLES`, 80000: wait after hold for clear/home; ≥ `EXEC_CYCLES`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: push request, sampled on posedge clk.
- `wr_rs`, in, 1: RS for the pushed byte (0 = command, 1 = data).
- `wr_data`, in, 8: byte to push.
- `clr_overflow`, in, 1: clears the sticky `overflow` flag.
- `full`, out, 1: FIFO holds `DEPTH` entries.
- `busy`, out, 1: FSM not IDLE, or FIFO not empty.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`, out, 1: sticky; set when a push is dropped.
- `lcd_data`, out, 8: LCD data bus.
- `lcd_ctrl`, out, 2: {RS, RW}; RW is always 0.
- `lcd_enable`, out, 1: LCD E strobe.

## Operation
- Reset values: FIFO empty, `level`=0, `full`=0, `busy`=0, `overflow`=0, `lcd_data`=0, `lcd_ctrl`=2'b00, `lcd_enable`=0, FSM in IDLE, delay counter 0.
- Push: if `wr_en` is high and the FIFO is not full, {rs,data} is written. If the FIFO is full, the push is dropped and `overflow` is set.
- Push into a full FIFO on the same edge as a pop is accepted, because a pop frees a slot first.
- `clr_overflow` clears `overflow`. If `clr_overflow` and a dropped push coincide, set wins.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE → SETUP when the FIFO is not empty. Pop the head, register it onto `lcd_data`/`lcd_ctrl[1]`, load the counter.
  - SETUP: `lcd_enable`=0 for SETUP_CYCLES cycles, then → PULSE.
  - PULSE: `lcd_enable`=1 for PULSE_CYCLES cycles, then → HOLD.
  - HOLD: `lcd_enable`=0 for HOLD_CYCLES cycles, then → WAIT.
  - WAIT: hold for LONG_EXEC_CYCLES if the entry was a clear/home command (RS=0 and data[7:1]==7'b0000000 with data[0]=1, or data[7:1]==7'b0000001); otherwise hold for EXEC_CYCLES.
  - At the end of WAIT: if the FIFO is not empty, pop and go directly to SETUP; otherwise go to IDLE.
- `lcd_data`/`lcd_ctrl` change only on a pop edge. They hold their last value in IDLE.
- Counters: down-counters sized $clog2(LONG_EXEC_CYCLES+1). A state lasting N cycles loads N-1 on entry and exits on the edge where the counter reads 0. There is no wrap.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Asserting reset mid-transaction aborts it: E drops asynchronously, the FIFO is flushed, and all outputs return to their reset values.

## Timing
- Push at edge N into an empty FIFO with the FSM idle:
  - edge N+1: pop; `lcd_data` valid and state = SETUP.
  - E rises at edge N+1+SETUP_CYCLES.
  - E falls PULSE_CYCLES later.
- Back-to-back entries: consecutive E rising edges are exactly SETUP+PULSE+HOLD+EXEC cycles apart (LONG_EXEC replaces EXEC after clear/home). There is no IDLE bubble.
- `level`, `full` and `busy` are registered and reflect pushes and pops of the previous edge. `busy` rises at edge N+1 after the first push.
- Pipeline latency from push to E high, FIFO empty: 1+SETUP_CYCLES cycles.

## Structure
- Shared package `lcd_pkg`:
  - FSM state encoding (IDLE, SETUP, PULSE, HOLD, WAIT).
  - Constants `LCD_CMD_CLEAR`=8'h01 and `LCD_CMD_HOME_MASK`=8'hFE / `LCD_CMD_HOME`=8'h02.
  - The `lcd_entry` width (9 bits: {rs,data}).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push/pop/full/empty/level), instantiated with WIDTH=9.
- The FSM and delay counter live in the top of this block.

## Test plan
Use SETUP=2, PULSE=3, HOLD=1, EXEC=4, LONG_EXEC=10, DEPTH=4 throughout.
- Reset, then idle → all outputs at reset values; `busy`=0 for 20 cycles.
- Single push {rs=1, data=8'h41} at edge 0 → `lcd_data`=8'h41 and `lcd_ctrl`=2'b10 at edge 1; E high during edges 3–5; `busy` low at edge 11.
- Four consecutive pushes (8'h30–8'h33, rs=1) → four E pulses with rising edges 10 cycles apart; data in order; `overflow`=0.
- Six pushes with no gap → the fifth push is accepted (pop at edge 1 frees a slot); the sixth is dropped; `overflow`=1 until `clr_overflow`; exactly five E pulses.
- Push {rs=0, 8'h01}, then {rs=1, 8'h42} → E rising edges 16 cycles apart (long exec). Repeat with 8'h03 (home), also 16 apart. With 8'h0C, 10 apart.
- Assert `rst_n` low while E=1 with 2 entries queued → E=0 immediately; `level`=0; no further pulses after release.
